// File: rtl/apb_pkg.sv
// Shared APB definitions: peripheral window, timer register offsets and CTRL layout.
// Also used by the initiator's address decoder.
package apb_pkg;

  localparam logic [31:0] APB_PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] APB_PERIPH_MASK = 32'hF000_0000;

  localparam logic [4:0] CTRL_OFF     = 5'h00;
  localparam logic [4:0] LOAD_OFF     = 5'h04;
  localparam logic [4:0] COUNT_OFF    = 5'h08;
  localparam logic [4:0] STATUS_OFF   = 5'h0C;
  localparam logic [4:0] PRESCALE_OFF = 5'h10;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  function automatic logic [4:0] reg_offset(input logic [2:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

  function automatic logic in_periph_window(input logic [31:0] addr);
    return (addr & APB_PERIPH_MASK) == APB_PERIPH_BASE;
  endfunction

endpackage

// File: rtl/apb_timer_slave_if.sv
// APB bus bundle between the core's initiator and a peripheral completer.
interface apb_timer_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY);
endinterface

// File: rtl/apb_slave_if.sv
// Reusable APB completer front end: SETUP/ACCESS detection, wait states,
// PREADY and the write-commit / read-sample strobes.
module apb_slave_if #(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic pready,
  output logic wr_commit,
  output logic rd_sample
);

  localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_STATES);

  logic [WCW-1:0] wait_cnt_q;
  logic [WCW-1:0] wait_cnt_d;
  logic           setup_s;
  logic           access_s;

  // Handshake decode; rst masks PREADY so a transfer in flight never completes under reset.
  always_comb begin
    setup_s   = psel & ~penable;
    access_s  = psel & penable;
    pready    = access_s & ~rst & (wait_cnt_q == WAIT_MAX);
    wr_commit = pready & pwrite;
    rd_sample = setup_s & ~pwrite;
    if (!psel || setup_s) begin
      wait_cnt_d = {WCW{1'b0}};
    end else if (!pready) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= {WCW{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer peripheral: prescaled down-counter with auto-reload, sticky
// expiry flag and registered level interrupt.
module apb_timer_slave import apb_pkg::*; #(
  parameter int          WAIT_STATES = 1,
  parameter int          PRESCALE_W  = 16,
  parameter logic [31:0] RESET_LOAD  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  apb_timer_slave_if.slave   apb,
  output logic               irq
);

  logic pready_s, wr_commit_s, rd_sample_s;

  apb_slave_if #(.WAIT_STATES(WAIT_STATES)) u_apb_if (
    .clk       (clk),
    .rst       (rst),
    .psel      (apb.PSEL),
    .penable   (apb.PENABLE),
    .pwrite    (apb.PWRITE),
    .pready    (pready_s),
    .wr_commit (wr_commit_s),
    .rd_sample (rd_sample_s)
  );

  ctrl_t                 ctrl_q, ctrl_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic                  expired_q, expired_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic                  irq_q, irq_d;
  logic [31:0]           prdata_q, prdata_d;

  logic [4:0]  off_s;
  logic        tick_s, expire_s, start_s, ctrl_wr_s, w1c_s;
  logic [31:0] rd_mux_s;
  logic        unused_addr_s;

  // Timer datapath and register-file next state; a CTRL write overrides the hardware EN clear.
  always_comb begin
    off_s         = reg_offset(apb.PADDR[4:2]);
    unused_addr_s = ^{apb.PADDR[31:5], apb.PADDR[1:0]};
    tick_s        = ctrl_q.en & (presc_cnt_q == prescale_q);
    expire_s      = tick_s & (count_q == 32'd0);
    ctrl_wr_s     = wr_commit_s & (off_s == CTRL_OFF);
    start_s       = ctrl_wr_s & ~ctrl_q.en & apb.PWDATA[CTRL_EN];
    w1c_s         = wr_commit_s & (off_s == STATUS_OFF) & apb.PWDATA[0];

    expired_d = expire_s | (expired_q & ~w1c_s);
    irq_d     = expired_q & ctrl_q.irq_en;

    if (start_s) begin
      presc_cnt_d = {PRESCALE_W{1'b0}};
    end else if (!ctrl_q.en) begin
      presc_cnt_d = presc_cnt_q;
    end else if (tick_s) begin
      presc_cnt_d = {PRESCALE_W{1'b0}};
    end else begin
      presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
    end

    if (start_s) begin
      count_d = load_q;
    end else if (expire_s && ctrl_q.auto_reload) begin
      count_d = load_q;
    end else if (tick_s && !expire_s) begin
      count_d = count_q - 32'd1;
    end else begin
      count_d = count_q;
    end

    if (ctrl_wr_s) begin
      ctrl_d = ctrl_t'(apb.PWDATA[2:0]);
    end else if (expire_s && !ctrl_q.auto_reload) begin
      ctrl_d = '{irq_en: ctrl_q.irq_en, auto_reload: ctrl_q.auto_reload, en: 1'b0};
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_commit_s && (off_s == LOAD_OFF)) begin
      load_d = apb.PWDATA;
    end else begin
      load_d = load_q;
    end

    if (wr_commit_s && (off_s == PRESCALE_OFF)) begin
      prescale_d = apb.PWDATA[PRESCALE_W-1:0];
    end else begin
      prescale_d = prescale_q;
    end

    rd_mux_s = 32'd0;
    case (off_s)
      CTRL_OFF:     rd_mux_s[2:0] = ctrl_q;
      LOAD_OFF:     rd_mux_s = load_q;
      COUNT_OFF:    rd_mux_s = count_q;
      STATUS_OFF:   rd_mux_s[0] = expired_q;
      PRESCALE_OFF: rd_mux_s[PRESCALE_W-1:0] = prescale_q;
      default:      rd_mux_s = 32'd0;
    endcase

    if (rd_sample_s) begin
      prdata_d = rd_mux_s;
    end else begin
      prdata_d = prdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= ctrl_t'(3'b000);
      load_q      <= RESET_LOAD;
      count_q     <= 32'd0;
      expired_q   <= 1'b0;
      prescale_q  <= {PRESCALE_W{1'b0}};
      presc_cnt_q <= {PRESCALE_W{1'b0}};
      irq_q       <= 1'b0;
      prdata_q    <= 32'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      count_q     <= count_d;
      expired_q   <= expired_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      irq_q       <= irq_d;
      prdata_q    <= prdata_d;
    end
  end

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = pready_s;
  assign irq        = irq_q;

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB responder (completer) holding a programmable down-counting timer with prescaler, auto-reload, sticky expiry flag and level interrupt.
- Sits on the peripheral bus behind the core's APB initiator in the 0x4000_0000 peripheral window.
- Answers SETUP/ACCESS transfers with a configurable number of wait states.
- Gives the core its first timing and interrupt source.

Parameters:
- WAIT_STATES, 1, number of ACCESS cycles with PREADY low before PREADY is asserted (0 = zero-wait).
- PRESCALE_W, 16, width of the prescaler register and counter.
- RESET_LOAD, 32'h0000_0000, reset value of the LOAD register.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; only PADDR[4:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid while PREADY is high in a read ACCESS cycle.
- PREADY  out  1  transfer-complete handshake.
- irq  out  1  level interrupt, registered.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is synchronous and active-high: rst, sampled on the rising edge of clk.
  - Reset values: PRDATA=0, PREADY=0, irq=0, CTRL=0, LOAD=RESET_LOAD, COUNT=0, STATUS=0, prescaler counter=0, wait counter=0.
- Register map (offset = PADDR[4:2]*4):
  - 0x00 CTRL RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 LOAD RW, 32 bits.
  - 0x08 COUNT RO; writes ignored.
  - 0x0C STATUS: bit0 EXPIRED, write-1-to-clear.
  - 0x10 PRESCALE RW, low PRESCALE_W bits, upper bits read 0.
  - Offsets 0x14–0x1C: reads return 0, writes ignored; no error response.
- APB handshake:
  - SETUP cycle (PSEL=1, PENABLE=0): wait counter cleared to 0. For reads, PRDATA is registered from the addressed register at this edge, so a COUNT read returns the SETUP-cycle value.
  - ACCESS cycles (PSEL=1, PENABLE=1): PREADY = (wait counter == WAIT_STATES), combinational from the registered counter. The wait counter increments each ACCESS cycle while PREADY=0.
  - PREADY is 0 whenever PSEL=0 or PENABLE=0.
  - Write commit happens only on the edge where PSEL&PENABLE&PREADY&PWRITE=1, exactly once per transfer.
  - PRDATA holds its value between transfers.
- Timer operation:
  - Writing CTRL with EN 0->1 loads COUNT<=LOAD and clears the prescaler counter on the same edge.
  - While EN=1: the prescaler counter counts 0..PRESCALE and emits a one-cycle tick on reaching PRESCALE, then wraps to 0. PRESCALE=0 gives a tick every cycle.
  - On a tick with COUNT!=0: COUNT<=COUNT-1.
  - On a tick with COUNT==0: EXPIRED<=1. If AUTO_RELOAD=1, COUNT<=LOAD; otherwise EN<=0 and COUNT stays 0.
  - A LOAD write while running does not touch COUNT until the next reload or re-enable.
  - EN 1->0 freezes COUNT and the prescaler.
- irq <= EXPIRED & IRQ_EN, registered; one cycle behind STATUS.
- Simultaneous events:
  - Hardware expiry and a W1C to STATUS on the same edge: EXPIRED=1 (set wins).
  - A CTRL write and a hardware EN auto-clear on the same edge: the written CTRL value wins.
- rst asserted mid-transfer: PREADY=0 next cycle and all state returns to reset. Any uncommitted write is dropped.
- PSEL dropped during wait states (protocol violation): wait counter cleared, no commit.

Decomposition:
- Shared package apb_pkg: register offset constants (CTRL_OFF, LOAD_OFF, COUNT_OFF, STATUS_OFF, PRESCALE_OFF), CTRL bit-index constants, APB base/mask constants reused by the initiator's decoder.
- One sub-module, apb_slave_if: SETUP/ACCESS detection, wait-state counter, PREADY generation, write-commit and read-sample strobes. It is reusable by future APB peripherals.
- Timer datapath and register file live in apb_timer_slave.

Test Plan:
- Reset then read every offset (WAIT_STATES=1) -> PREADY exactly one ACCESS cycle late; data CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, 0x14=0.
- Write LOAD=5, PRESCALE=0, CTRL=0x1 -> COUNT reads 5,4,..0 one per cycle; EXPIRED=1 on the tick after 0; EN auto-clears; COUNT stays 0.
- LOAD=2, PRESCALE=3, CTRL=0x7 -> tick every 4 cycles; expiry every 12 cycles; COUNT reloads to 2; irq rises one cycle after EXPIRED.
- W1C STATUS=0x1 on the same edge as hardware expiry -> EXPIRED stays 1. W1C on a quiet cycle -> EXPIRED=0 and irq=0 one cycle later.
- rst pulsed during the second ACCESS wait cycle of a LOAD=0xDEADBEEF write -> LOAD reads RESET_LOAD and PREADY=0 the cycle after rst.
- Rebuild with WAIT_STATES=0 and do back-to-back write/read of PRESCALE=0x1_FFFF -> PREADY in the first ACCESS cycle; reads 0xFFFF (16-bit truncation).
